load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory data-bus width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for data_valid; SHALL be ≥1. BYTES = DATA_WIDTH/8 is derived.
REQ-004 Ports, in this order:
- clk, in, 1, clock.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request accepted when high together with req_valid.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, ADDR_WIDTH, byte address.
- req_size, in, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned, in, 1, load zero-extends instead of sign-extending.
- req_wdata, in, DATA_WIDTH, store data, right-justified.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, DATA_WIDTH, extended load data; 0 for stores and errors.
- rsp_misaligned, out, 1, alignment or size error.
- rsp_timeout, out, 1, memory did not answer.
- data_req, out, 1, memory request.
- data_we, out, 1, memory write.
- data_addr, out, ADDR_WIDTH, BYTES-aligned address.
- data_wdata, out, DATA_WIDTH, lane-aligned store data.
- data_byte_enable, out, BYTES, active lanes.
- data_valid, in, 1, memory completion.
- data_rdata, in, DATA_WIDTH, memory read data.

Function
REQ-005 The unit SHALL implement an FSM with states IDLE, ACCESS and RESP, and SHALL hold at most one request in flight.
REQ-006 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready it SHALL latch we, addr, size, unsigned and wdata.
REQ-007 size_bytes = 1<<req_size and offset = addr mod BYTES; the request is misaligned if size_bytes > BYTES or offset mod size_bytes ≠ 0.
REQ-008 IDLE, misaligned accept: next state RESP with rsp_misaligned=1, rsp_data=0, and data_req never asserted.
REQ-009 IDLE, aligned accept: next state ACCESS; data_req SHALL be 1 from the following cycle.
REQ-010 In ACCESS, data_addr SHALL be the latched addr with its low log2(BYTES) bits cleared.
REQ-011 In ACCESS, data_byte_enable SHALL be ((1<<size_bytes)-1)<<offset.
REQ-012 In ACCESS, data_wdata SHALL be the latched wdata shifted left by 8*offset.
REQ-013 data_req, data_we, data_addr, data_byte_enable and data_wdata SHALL stay stable throughout ACCESS.
REQ-014 On data_valid in ACCESS:
- Loads: rsp_data = (data_rdata >> 8*offset), truncated to size_bytes and sign-extended (zero-extended if unsigned).
- Stores: rsp_data = 0.
- Next state RESP; data_req SHALL drop the next cycle.
REQ-015 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without data_valid. When it reaches TIMEOUT_CYCLES, next state RESP with rsp_timeout=1 and rsp_data=0.
REQ-016 data_valid in the same cycle as the timeout SHALL win: normal completion, rsp_timeout=0.
REQ-017 data_valid outside ACCESS SHALL be ignored.
REQ-018 In RESP, rsp_valid=1 and rsp_data, rsp_misaligned and rsp_timeout SHALL be held stable until rsp_ready; then next state IDLE.
REQ-019 Latency: data_valid in cycle M gives rsp_valid in cycle M+1; a misaligned request accepted in cycle N gives rsp_valid in N+1.
REQ-020 Outside ACCESS, data_* outputs SHALL be 0. Outside RESP, rsp_* outputs SHALL be 0.

Reset
REQ-021 On rst at any clock edge, including mid-ACCESS or mid-RESP: state IDLE, wait counter 0, all latched fields 0.
REQ-022 Next cycle after reset: req_ready=1 and every other output 0; any pending memory completion SHALL be discarded.

Structure
REQ-023 A shared package lsu_pkg SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W, SIZE_D) and the FSM state encodings.
REQ-024 Lane logic (byte-enable generation, store shift, load shift/extend) SHALL be one combinational sub-module, lsu_lane_align, instantiated once.

Verification (DATA_WIDTH=32)
REQ-025 Store byte at 0x1003 with wdata 0x000000AB -> data_addr 0x1000, data_byte_enable 4'b1000, data_wdata 0xAB000000; after data_valid, rsp_data 0.
REQ-026 Load half at 0x2002, data_rdata 0x80011234 -> signed: rsp_data 0xFFFF8001; req_unsigned=1: rsp_data 0x00008001.
REQ-027 Load word at 0x3002, and load double at 0x3000 -> rsp_misaligned=1 one cycle after accept; data_req stays 0.
REQ-028 TIMEOUT_CYCLES=4, data_valid never asserted -> data_req high 4 cycles, then rsp_timeout=1. Repeat with data_valid on cycle 4 -> rsp_timeout=0.
REQ-029 rsp_ready held low 3 cycles in RESP -> rsp_* outputs unchanged and req_ready=0; after rsp_ready, the next request is accepted the following cycle.
REQ-030 rst asserted mid-ACCESS, with data_valid the next cycle -> data_req=0, req_ready=1, and no rsp_valid produced.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used at request acceptance.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic int size_bytes(input logic [1:0] size);
        int nb;
        unique case (size)
            SIZE_B:  nb = 1;
            SIZE_H:  nb = 2;
            SIZE_W:  nb = 4;
            default: nb = 8;
        endcase
        return nb;
    endfunction

    // Sizes wider than the bus are reported as misaligned as well.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset,
                                           input int bytes);
        int sb;
        sb = size_bytes(size);
        return (sb > bytes) || ((int'(offset) & (sb - 1)) != 0);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store data placement and
// load data extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
    input  logic [1:0]                      size,
    input  logic                            is_unsigned,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH-1:0]           rdata,
    output logic [DATA_WIDTH/8-1:0]         byte_enable,
    output logic [DATA_WIDTH-1:0]           wdata_aligned,
    output logic [DATA_WIDTH-1:0]           rdata_ext
);

    localparam int BYTES = DATA_WIDTH / 8;

    int                    eff_bytes;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign;

    always_comb begin
        eff_bytes     = size_bytes(size);
        if (eff_bytes > BYTES) eff_bytes = BYTES;
        shifted       = rdata >> {offset, 3'b000};
        wdata_aligned = wdata << {offset, 3'b000};
        sign          = 1'b0;
        byte_enable   = '0;
        rdata_ext     = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i == eff_bytes - 1) sign = shifted[8*i+7] & ~is_unsigned;
            byte_enable[i] = (i >= int'(offset)) && (i < int'(offset) + eff_bytes);
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rdata_ext[i] = (i < 8 * eff_bytes) ? shifted[i] : sign;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a request/response port to a
// memory bus, with alignment checking and a completion timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_misaligned,
    output logic                    rsp_timeout,
    output logic                    data_req,
    output logic                    data_we,
    output logic [ADDR_WIDTH-1:0]   data_addr,
    output logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH/8-1:0] data_byte_enable,
    input  logic                    data_valid,
    input  logic [DATA_WIDTH-1:0]   data_rdata
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state, state_next;
    logic                  we_q, uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_mis_q, rsp_to_q;

    logic                  req_fire, req_mis, wait_expired;
    logic [BYTES-1:0]      lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata, lane_rdata;

    // Handshake: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid never waits on ready.
    assign req_fire     = (state == ST_IDLE) && req_valid;
    assign req_mis      = is_misaligned(req_size, 3'(req_addr[OFF_W-1:0]), BYTES);
    assign wait_expired = !data_valid && (wait_cnt == CNT_LAST);

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .offset        (addr_q[OFF_W-1:0]),
        .size          (size_q),
        .is_unsigned   (uns_q),
        .wdata         (wdata_q),
        .rdata         (data_rdata),
        .byte_enable   (lane_be),
        .wdata_aligned (lane_wdata),
        .rdata_ext     (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (req_valid) state_next = req_mis ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (data_valid || wait_expired) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_data         = '0;
        rsp_misaligned   = 1'b0;
        rsp_timeout      = 1'b0;
        data_req         = 1'b0;
        data_we          = 1'b0;
        data_addr        = '0;
        data_wdata       = '0;
        data_byte_enable = '0;
        unique case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_ACCESS: begin
                data_req         = 1'b1;
                data_we          = we_q;
                data_addr        = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                data_wdata       = lane_wdata;
                data_byte_enable = lane_be;
            end
            ST_RESP: begin
                rsp_valid      = 1'b1;
                rsp_data       = rsp_data_q;
                rsp_misaligned = rsp_mis_q;
                rsp_timeout    = rsp_to_q;
            end
            default: ;
        endcase
    end

    // Request fields, wait counter and the held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_mis_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else if (req_fire) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            addr_q     <= req_addr;
            size_q     <= req_size;
            wdata_q    <= req_wdata;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_mis_q  <= req_mis;
            rsp_to_q   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (data_valid) begin
                rsp_data_q <= we_q ? '0 : lane_rdata;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_expired) rsp_to_q <= 1'b1;
            end
        end
    end

endmodule
